// File: rtl/edge_scan_sequencer.sv
// Star-box scan sequencer: seed -> top/bottom map -> left/right map -> bounding box report.
// start->go_tb 2 cycles, tb_found->go_lr 2 cycles, last found->box_valid 2 cycles; box_valid holds until box_ready.
module edge_scan_sequencer #(
    parameter int          XSZ     = 8,
    parameter int          YSZ     = 7,
    parameter logic [19:0] TIMEOUT = 20'd65535
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [XSZ-1:0] star_x,
    input  logic [YSZ-1:0] star_y,
    output logic           go_tb,
    input  logic           tb_found,
    input  logic [YSZ-1:0] most_top,
    input  logic [YSZ-1:0] most_bottom,
    output logic           go_lr,
    output logic [XSZ-1:0] mid_pix,
    input  logic           left_found,
    input  logic           right_found,
    input  logic [XSZ-1:0] most_left,
    input  logic [XSZ-1:0] most_right,
    output logic [YSZ-1:0] box_top,
    output logic [YSZ-1:0] box_bottom,
    output logic [XSZ-1:0] box_left,
    output logic [XSZ-1:0] box_right,
    output logic [XSZ:0]   box_w,
    output logic [YSZ:0]   box_h,
    output logic           box_valid,
    input  logic           box_ready,
    output logic           busy,
    output logic           err
);

    typedef enum logic [2:0] {
        IDLE, LAUNCH_TB, WAIT_TB, LAUNCH_LR, WAIT_LR, REPORT, ABORT
    } state_t;

    localparam logic [XSZ:0] ONE_X = {{XSZ{1'b0}}, 1'b1};
    localparam logic [YSZ:0] ONE_Y = {{YSZ{1'b0}}, 1'b1};

    state_t         state;
    state_t         nextState;
    logic [19:0]    wdCnt;
    logic [YSZ-1:0] starY;
    logic           lDone;
    logic           rDone;
    logic           wdExpired;
    logic           tbBad;
    logic           lrBad;
    logic           latchTb;
    logic           latchL;
    logic           latchR;
    logic           enterReport;

    assign wdExpired = (wdCnt == TIMEOUT - 20'd1);
    // Seed row must lie inside the mapped column span, and the span must be ordered.
    assign tbBad = (most_top > most_bottom) || (starY < most_top) || (starY > most_bottom);
    assign lrBad = (box_left > mid_pix) || (box_right < mid_pix);

    always_comb begin
        nextState   = state;
        busy        = (state != IDLE);
        err         = 1'b0;
        box_valid   = 1'b0;
        latchTb     = 1'b0;
        latchL      = 1'b0;
        latchR      = 1'b0;
        enterReport = 1'b0;
        case (state)
            IDLE: begin
                if (start) nextState = LAUNCH_TB;
            end
            LAUNCH_TB: nextState = WAIT_TB;
            WAIT_TB: begin
                if (tb_found) begin
                    latchTb   = 1'b1;
                    nextState = tbBad ? ABORT : LAUNCH_LR;
                end else if (wdExpired) begin
                    nextState = ABORT;
                end
            end
            LAUNCH_LR: nextState = WAIT_LR;
            WAIT_LR: begin
                latchL = left_found && !lDone;
                latchR = right_found && !rDone;
                if (lDone && rDone) begin
                    enterReport = !lrBad;
                    nextState   = lrBad ? ABORT : REPORT;
                end else if (wdExpired) begin
                    nextState = ABORT;
                end
            end
            REPORT: begin
                box_valid = 1'b1;
                if (box_ready) nextState = IDLE;
            end
            ABORT: begin
                err       = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            wdCnt      <= '0;
            starY      <= '0;
            lDone      <= 1'b0;
            rDone      <= 1'b0;
            go_tb      <= 1'b0;
            go_lr      <= 1'b0;
            mid_pix    <= '0;
            box_top    <= '0;
            box_bottom <= '0;
            box_left   <= '0;
            box_right  <= '0;
            box_w      <= '0;
            box_h      <= '0;
        end else begin
            state <= nextState;
            go_tb <= (state == LAUNCH_TB);
            go_lr <= (state == LAUNCH_LR);

            if (state == WAIT_TB || state == WAIT_LR) wdCnt <= wdCnt + 20'd1;
            else                                      wdCnt <= '0;

            if (state == IDLE && start) begin
                mid_pix <= star_x;
                starY   <= star_y;
            end

            if (latchTb) begin
                box_top    <= most_top;
                box_bottom <= most_bottom;
            end

            // Flags are sticky for one scan; the first reported extent wins.
            if (state != WAIT_LR) begin
                lDone <= 1'b0;
                rDone <= 1'b0;
            end else begin
                if (latchL) begin
                    lDone    <= 1'b1;
                    box_left <= most_left;
                end
                if (latchR) begin
                    rDone     <= 1'b1;
                    box_right <= most_right;
                end
            end

            if (enterReport) begin
                box_w <= {1'b0, box_right} - {1'b0, box_left} + ONE_X;
                box_h <= {1'b0, box_bottom} - {1'b0, box_top} + ONE_Y;
            end
        end
    end

endmodule
